// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path.
//   tx_state_t  : transmitter FSM state encoding
//   PAR_EVEN/PAR_ODD : values of the PAR_TYP select
//   START_BIT/STOP_BIT/IDLE_LEVEL : serial line levels
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic PAR_EVEN   = 1'b0;
  localparam logic PAR_ODD    = 1'b1;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage : uart_pkg

// File: rtl/uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer
// Holds the payload shift register and data bit counter for one frame.
// Ports:
//   CLK, RST   : clock, asynchronous active-low reset
//   load       : capture load_data and restart the bit counter
//   shift      : end of a data bit; shift right and advance bit_cnt
//   load_data  : word to serialize
//   ser_data   : data bit that will be on the line after this clock edge
//   ser_done   : current data bit is the last one of the word
// ---------------------------------------------------------------------------
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  ser_data,
  output logic                  ser_done
);

  localparam int BIT_CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

  logic [DATA_WIDTH-1:0] shift_reg;
  logic [BIT_CNT_W-1:0]  bit_cnt;

  // The last data bit clears the counter on its way out of DATA, so the
  // next frame always starts at bit 0 even without a load.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (load) begin
      shift_reg <= load_data;
      bit_cnt   <= '0;
    end else if (shift) begin
      shift_reg <= shift_reg >> 1;
      bit_cnt   <= ser_done ? '0 : bit_cnt + BIT_CNT_W'(1);
    end
  end

  assign ser_done = (bit_cnt == BIT_CNT_W'(DATA_WIDTH - 1));

  // The top registers TX_OUT from this value, so on a shift it must
  // already show the bit that moves into position 0.
  assign ser_data = shift ? shift_reg[1] : shift_reg[0];

endmodule : uart_tx_serializer

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional
// parity bit, one stop bit. Every bit lasts prescale clock cycles.
// Ports:
//   CLK        : UART clock
//   RST        : asynchronous active-low reset
//   P_DATA     : word to send
//   DATA_VALID : send request (pulse or level)
//   PAR_EN     : 1 = append parity bit
//   PAR_TYP    : 0 = even, 1 = odd parity
//   prescale   : clock cycles per bit (0 behaves as 1)
//   TX_OUT     : registered serial line, idle high
//   busy       : registered, high while a frame is in progress; low in the
//                final stop-bit cycle so a new word can be accepted there
// ---------------------------------------------------------------------------
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      DATA_VALID,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      TX_OUT,
  output logic                      busy
);

  tx_state_t                 state_q, state_d;
  logic [PRESCALE_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
  logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
  logic [PRESCALE_WIDTH-1:0] prescale_eff;
  logic                      par_en_q;
  logic                      par_bit_q;
  logic                      tx_out_q, tx_out_d;
  logic                      busy_q, busy_d;

  logic last_edge;
  logic accept;
  logic load;
  logic shift;
  logic ser_data;
  logic ser_done;

  assign prescale_eff = (prescale == '0) ? PRESCALE_WIDTH'(1) : prescale;
  assign last_edge    = (edge_cnt_q == prescale_q - PRESCALE_WIDTH'(1));

  // A new word is taken either from idle or in the final stop-bit cycle,
  // which is what makes back-to-back frames possible with no idle gap.
  assign accept = DATA_VALID &&
                  ((state_q == IDLE) || ((state_q == STOP) && last_edge));
  assign load   = accept;
  assign shift  = (state_q == DATA) && last_edge;

  uart_tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_serializer (
    .CLK       (CLK),
    .RST       (RST),
    .load      (load),
    .shift     (shift),
    .load_data (P_DATA),
    .ser_data  (ser_data),
    .ser_done  (ser_done)
  );

  // State, counters and frame settings; outputs are registered alongside
  // so that TX_OUT and busy change on the same edge as the state.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      edge_cnt_q <= '0;
      prescale_q <= PRESCALE_WIDTH'(1);
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      tx_out_q   <= IDLE_LEVEL;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_cnt_q <= edge_cnt_d;
      prescale_q <= prescale_d;
      tx_out_q   <= tx_out_d;
      busy_q     <= busy_d;
      if (load) begin
        par_en_q  <= PAR_EN;
        par_bit_q <= (^P_DATA) ^ (PAR_TYP == PAR_ODD);
      end
    end
  end

  // Next-state and edge counter: each state lasts prescale_q cycles and the
  // edge counter wraps to zero at every bit boundary.
  always_comb begin
    state_d    = state_q;
    edge_cnt_d = edge_cnt_q + PRESCALE_WIDTH'(1);
    prescale_d = prescale_q;
    case (state_q)
      IDLE: begin
        edge_cnt_d = '0;
        if (accept) begin
          state_d    = START;
          prescale_d = prescale_eff;
        end
      end
      START: begin
        if (last_edge) begin
          state_d    = DATA;
          edge_cnt_d = '0;
        end
      end
      DATA: begin
        if (last_edge) begin
          edge_cnt_d = '0;
          if (ser_done) begin
            state_d = par_en_q ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (last_edge) begin
          state_d    = STOP;
          edge_cnt_d = '0;
        end
      end
      STOP: begin
        if (last_edge) begin
          edge_cnt_d = '0;
          if (accept) begin
            state_d    = START;
            prescale_d = prescale_eff;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        edge_cnt_d = '0;
      end
    endcase
  end

  // Output values for the state being entered; busy drops for the last
  // cycle of the stop bit.
  always_comb begin
    tx_out_d = IDLE_LEVEL;
    case (state_d)
      IDLE:    tx_out_d = IDLE_LEVEL;
      START:   tx_out_d = START_BIT;
      DATA:    tx_out_d = ser_data;
      PARITY:  tx_out_d = par_bit_q;
      STOP:    tx_out_d = STOP_BIT;
      default: tx_out_d = IDLE_LEVEL;
    endcase
    busy_d = (state_d != IDLE) &&
             !((state_d == STOP) &&
               (edge_cnt_d == prescale_d - PRESCALE_WIDTH'(1)));
  end

  assign TX_OUT = tx_out_q;
  assign busy   = busy_q;

endmodule : uart_tx

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx
// Self-checking bench for uart_tx: table of single frames with hand-written
// line patterns, plus back-to-back, ignored-request and mid-frame reset
// sequences.
// ---------------------------------------------------------------------------
module tb_uart_tx;

  logic       CLK;
  logic       RST;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] prescale;
  logic       TX_OUT;
  logic       busy;

  int compared   = 0;
  int mismatched = 0;

  uart_tx #(
    .DATA_WIDTH     (8),
    .PRESCALE_WIDTH (6)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .prescale   (prescale),
    .TX_OUT     (TX_OUT),
    .busy       (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // bits[i] is the i-th bit on the line (bit 0 = start bit)
  typedef struct {
    logic [7:0]  data;
    logic        pe;
    logic        pt;
    logic [5:0]  ps;
    int          eps;
    int          nbits;
    logic [10:0] bits;
  } vec_t;

  vec_t vecs[7];

  task automatic check_output(input string name, input logic actual,
                              input logic expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    end
  endtask

  // Offer one word with DATA_VALID high for the next rising edge
  task automatic apply_stimulus(input logic [7:0] data, input logic pe,
                                input logic pt, input logic [5:0] ps);
    @(negedge CLK);
    P_DATA     = data;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    prescale   = ps;
    DATA_VALID = 1'b1;
  endtask

  // Check every cycle of a frame. After the checks of cycle inj_cycle the
  // bench raises DATA_VALID with inj_data; otherwise DATA_VALID = dv_level.
  task automatic run_frame(input logic [10:0] bits, input int nbits,
                           input int eps, input string tag,
                           input int inj_cycle, input logic [7:0] inj_data,
                           input logic dv_level);
    int total;
    total = nbits * eps;
    for (int c = 0; c < total; c++) begin
      @(negedge CLK);
      check_output($sformatf("%s_tx_c%0d", tag, c), TX_OUT, bits[c / eps]);
      check_output($sformatf("%s_busy_c%0d", tag, c), busy, (c != total - 1));
      DATA_VALID = dv_level;
      if (c == 0 && !dv_level) begin
        P_DATA   = ~P_DATA;
        PAR_EN   = ~PAR_EN;
        PAR_TYP  = ~PAR_TYP;
        prescale = prescale + 6'd3;
      end
      if (c == inj_cycle) begin
        P_DATA     = inj_data;
        DATA_VALID = 1'b1;
      end
    end
  endtask

  task automatic check_idle(input string tag, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge CLK);
      check_output($sformatf("%s_idle_tx_c%0d", tag, c), TX_OUT, 1'b1);
      check_output($sformatf("%s_idle_busy_c%0d", tag, c), busy, 1'b0);
    end
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 6'd8, 8, 10, 11'b01101001010};
    vecs[1] = '{8'hA5, 1'b1, 1'b0, 6'd4, 4, 11, 11'b10101001010};
    vecs[2] = '{8'hA5, 1'b1, 1'b1, 6'd4, 4, 11, 11'b11101001010};
    vecs[3] = '{8'h01, 1'b1, 1'b0, 6'd4, 4, 11, 11'b11000000010};
    vecs[4] = '{8'h81, 1'b0, 1'b0, 6'd0, 1, 10, 11'b01100000010};
    vecs[5] = '{8'h00, 1'b1, 1'b1, 6'd2, 2, 11, 11'b11000000000};
    vecs[6] = '{8'hFF, 1'b1, 1'b0, 6'd3, 3, 11, 11'b10111111110};

    RST        = 1'b0;
    P_DATA     = 8'h00;
    DATA_VALID = 1'b0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    prescale   = 6'd1;

    // Reset state
    repeat (3) @(negedge CLK);
    check_output("reset_tx", TX_OUT, 1'b1);
    check_output("reset_busy", busy, 1'b0);
    RST = 1'b1;
    check_idle("post_reset", 2);

    // Single frames from the table
    for (int i = 0; i < 7; i++) begin
      apply_stimulus(vecs[i].data, vecs[i].pe, vecs[i].pt, vecs[i].ps);
      run_frame(vecs[i].bits, vecs[i].nbits, vecs[i].eps,
                $sformatf("vec%0d", i), -1, 8'h00, 1'b0);
      check_idle($sformatf("vec%0d", i), 2);
    end

    // Back-to-back: DATA_VALID held, 0x0F offered in the last stop cycle
    apply_stimulus(8'h55, 1'b0, 1'b0, 6'd4);
    run_frame(11'b01010101010, 10, 4, "b2b_first", 39, 8'h0F, 1'b1);
    run_frame(11'b01000011110, 10, 4, "b2b_second", -1, 8'h00, 1'b0);
    check_idle("b2b", 2);

    // Request while busy is dropped
    apply_stimulus(8'hA5, 1'b0, 1'b0, 6'd4);
    run_frame(11'b01101001010, 10, 4, "ignore", 10, 8'hFF, 1'b0);
    check_idle("ignore", 50);

    // Asynchronous reset during data bit 3 of a 0x00 frame
    apply_stimulus(8'h00, 1'b0, 1'b0, 6'd4);
    for (int c = 0; c < 18; c++) begin
      @(negedge CLK);
      DATA_VALID = 1'b0;
      check_output($sformatf("rst_frame_tx_c%0d", c), TX_OUT, 1'b0);
      check_output($sformatf("rst_frame_busy_c%0d", c), busy, 1'b1);
    end
    #2;
    RST = 1'b0;
    #1;
    check_output("async_rst_tx", TX_OUT, 1'b1);
    check_output("async_rst_busy", busy, 1'b0);
    @(negedge CLK);
    check_output("rst_hold_tx", TX_OUT, 1'b1);
    check_output("rst_hold_busy", busy, 1'b0);
    RST = 1'b1;
    check_idle("rst_release", 2);

    apply_stimulus(8'h3C, 1'b0, 1'b0, 6'd1);
    run_frame(11'b01001111000, 10, 1, "after_rst", -1, 8'h00, 1'b0);
    check_idle("after_rst", 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_uart_tx

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter that serializes one 8-bit word per frame onto the serial line. Each frame is a start bit, 8 data bits LSB first, an optional parity bit and one stop bit. It runs on the same UART clock domain and oversampling prescale as the receiver, so each bit is held for `prescale` clock cycles. It sits between the TX-side data source (register file / ALU result path via a CDC FIFO) and the TX pin.

Parameters:
- DATA_WIDTH, 8, payload bits per frame.
- PRESCALE_WIDTH, 6, width of the prescale input.

Ports:
- CLK  input  1  UART clock.
- RST  input  1  reset; asynchronous, active-low.
- P_DATA  input  DATA_WIDTH  parallel word to send.
- DATA_VALID  input  1  request to send P_DATA; a one-cycle pulse or a level are both legal.
- PAR_EN  input  1  1 = insert parity bit.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- prescale  input  PRESCALE_WIDTH  clock cycles per bit; 0 is treated as 1.
- TX_OUT  output  1  serial line; idle high.
- busy  output  1  1 = frame in progress, DATA_VALID ignored.

Behaviour:
- Reset (async, RST=0): state IDLE; TX_OUT=1; busy=0; shift register, bit counter and edge counter cleared. Reset mid-frame aborts the frame immediately: the line returns high with no partial stop bit.
- TX_OUT and busy are registered, with no combinational path from any input.
- Accept condition:
  - DATA_VALID=1 sampled at a rising edge while (state==IDLE) or (state==STOP and edge_cnt==prescale_q-1).
  - On accept, latch P_DATA, PAR_EN, PAR_TYP and prescale (0 becomes 1) into frame registers.
  - Compute parity at latch time: even = XOR(P_DATA); odd = ~XOR(P_DATA).
  - Input changes after accept do not affect the current frame.
- Latency: accept at edge N gives TX_OUT=0 (start) and busy=1 from edge N.
- States:
  - IDLE: TX_OUT=1, busy=0. Accept goes to START.
  - START: TX_OUT=0 for prescale_q cycles, then DATA.
  - DATA: TX_OUT = shift_reg[0] for prescale_q cycles per bit; shift right at the end of each bit. After bit 7 ends, go to PARITY if par_en_q, else STOP.
  - PARITY: TX_OUT = par_bit_q for prescale_q cycles, then STOP.
  - STOP: TX_OUT=1 for prescale_q cycles.
    - At the last cycle, accept gives START with no idle gap (back-to-back); otherwise go to IDLE.
    - busy is 0 during the last STOP cycle, signalling that the next word may be offered.
- Counters:
  - edge_cnt runs 0..prescale_q-1 and wraps at each bit boundary.
  - bit_cnt runs 0..7, advances only in DATA, and clears on leaving DATA.
- Frame length: (10 + par_en_q) * prescale_q cycles.
- DATA_VALID while busy=1 is dropped, with no queuing; the source must hold or retry.
- Illegal state encoding recovers to IDLE with TX_OUT=1.

Decomposition:
- Package uart_pkg holds:
  - TX state encodings IDLE/START/DATA/PARITY/STOP;
  - PAR_EVEN=0 and PAR_ODD=1;
  - START_BIT=0, STOP_BIT=1 and IDLE_LEVEL=1.
- Sub-module uart_tx_serializer:
  - DATA_WIDTH shift register, bit_cnt and done flag;
  - driven by load/shift strobes from the FSM;
  - outputs ser_data and ser_done.
- The top uart_tx holds the FSM, edge counter, parity register and output mux/register.

Test Plan:
1. prescale=8, PAR_EN=0, P_DATA=0xA5, one-cycle DATA_VALID pulse:
   - TX_OUT = 0,1,0,1,0,0,1,0,1,1, each bit 8 cycles, 80 cycles total;
   - busy=1 for 79 cycles, then IDLE.
2. prescale=4, PAR_EN=1:
   - 0xA5 with PAR_TYP=0 gives parity bit 0; with PAR_TYP=1 gives parity bit 1;
   - 0x01 with PAR_TYP=0 gives parity bit 1;
   - each frame is 44 cycles.
3. Back-to-back, prescale=4, DATA_VALID held high with 0x55 then 0x0F offered in the last STOP cycle:
   - the second start bit follows the stop bit with zero idle cycles;
   - busy is low for exactly one cycle between frames.
4. Pulse DATA_VALID with P_DATA=0xFF at cycle 10 of a frame in progress:
   - ignored; the frame completes unchanged and no second frame is sent.
5. Assert RST=0 during data bit 3 of a 0x00 frame:
   - TX_OUT=1 and busy=0 immediately, without waiting for a clock edge.
   - After release, send 0x3C at prescale=1: 10-cycle frame 0,0,0,1,1,1,1,0,0,1.
6. prescale=0 with 0x81:
   - behaves as prescale=1: 10-cycle frame 0,1,0,0,0,0,0,0,1,1.
